// File: rtl/syn_var_delay_with_enable.sv
// -----------------------------------------------------------------------------
// syn_var_delay_with_enable
//
// Variable-length sample delay line with a sample enable. All CHANNELS lanes
// share one circular buffer and one delay setting d. With d >= 1 the output is
// the input from d-1 enabled edges before the latest one, registered, so the
// total latency is d enabled samples. With d = 0 the input passes straight
// through combinationally.
//
// Ports
//   clk      in   1                  sole clock, rising edge
//   grst     in   1                  global reset, asynchronous, active-high
//   rst      in   1                  synchronous clear, active-high
//   en       in   1                  sample enable; state advances only when high
//   dly_ld   in   1                  load-new-delay strobe
//   dly      in   DW                 requested delay, sampled when dly_ld = 1
//   inp      in   BITWIDTH*CHANNELS  input samples, channel 0 at the LSBs
//   outp     out  BITWIDTH*CHANNELS  delayed samples (zero until valid)
//   outv     out  1                  outp holds genuine delayed data
//   dly_cur  out  DW                 active delay d
//   dly_err  out  1                  sticky: a load requested dly > MAXDELAY
// -----------------------------------------------------------------------------
module syn_var_delay_with_enable #(
  parameter int BITWIDTH = 16,
  parameter int CHANNELS = 1,
  parameter int MAXDELAY = 256,
  parameter int DEFDELAY = 1,
  localparam int DW = $clog2(MAXDELAY + 1)
) (
  input  logic                         clk,
  input  logic                         grst,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         dly_ld,
  input  logic [DW-1:0]                dly,
  input  logic [BITWIDTH*CHANNELS-1:0] inp,
  output logic [BITWIDTH*CHANNELS-1:0] outp,
  output logic                         outv,
  output logic [DW-1:0]                dly_cur,
  output logic                         dly_err
);

  localparam int WD = BITWIDTH * CHANNELS;
  localparam int AW = $clog2(MAXDELAY);

  localparam logic [DW-1:0] MAXD_DW  = DW'(MAXDELAY);
  localparam logic [DW-1:0] DEFD_DW  = DW'(DEFDELAY);
  localparam logic [AW:0]   MAXD_AW1 = (AW + 1)'(MAXDELAY);
  localparam logic [AW-1:0] WP_LAST  = AW'(MAXDELAY - 1);

  // Sample store: no reset, so it maps onto block RAM. Stale contents after
  // any clear are never shown because the output is gated by the fill count.
  logic [WD-1:0] r_mem [MAXDELAY];

  logic [AW-1:0] r_wp;
  logic [DW-1:0] r_fill;
  logic [DW-1:0] r_d;
  logic          r_outv;
  logic          r_err;
  logic [WD-1:0] r_ram_q;
  logic [WD-1:0] r_byp_q;

  logic          w_adv;
  logic          w_dly_over;
  logic [DW-1:0] w_dly_clamp;
  logic [DW-1:0] w_fill_next;
  logic [AW-1:0] w_wp_next;
  logic [DW-1:0] w_back;
  logic [AW:0]   w_ra_sum;
  logic [AW-1:0] w_ra;
  logic          w_d_zero;
  logic [WD-1:0] w_q;

  // A sample is captured only on an enabled edge that is not also a clear or
  // a delay load; those two take priority over en.
  assign w_adv       = en & ~rst & ~dly_ld;
  assign w_dly_over  = (dly > MAXD_DW);
  assign w_dly_clamp = w_dly_over ? MAXD_DW : dly;
  assign w_fill_next = (r_fill == MAXD_DW) ? r_fill : r_fill + DW'(1);
  assign w_wp_next   = (r_wp == WP_LAST) ? '0 : r_wp + AW'(1);
  assign w_d_zero    = (r_d == '0);

  // Read address (wp - (d-1)) mod MAXDELAY. Adding MAXDELAY first keeps the
  // intermediate positive, so one conditional subtract finishes the modulo.
  // For d = 0 the RAM is unused; pin the address to wp so it stays in range.
  assign w_back   = r_d - DW'(1);
  assign w_ra_sum = {1'b0, r_wp} + MAXD_AW1 - (AW + 1)'(w_back);

  always_comb begin
    w_ra = r_wp;
    if (!w_d_zero) begin
      if (w_ra_sum >= MAXD_AW1) begin
        w_ra = AW'(w_ra_sum - MAXD_AW1);
      end else begin
        w_ra = AW'(w_ra_sum);
      end
    end
  end

  // Datapath: write and registered read share the same enable. With d = 1
  // the read address equals the write address, so the RAM returns the old
  // word; the bypass register carries the sample being written instead.
  always_ff @(posedge clk) begin
    if (!grst && w_adv) begin
      r_mem[r_wp] <= inp;
      r_ram_q     <= r_mem[w_ra];
      r_byp_q     <= inp;
    end
  end

  // Control state. Clearing fill on every load guarantees that samples
  // captured under a previous delay can never reach the output.
  always_ff @(posedge clk or posedge grst) begin
    if (grst) begin
      r_wp   <= '0;
      r_fill <= '0;
      r_d    <= DEFD_DW;
      r_outv <= 1'b0;
      r_err  <= 1'b0;
    end else if (rst) begin
      r_wp   <= '0;
      r_fill <= '0;
      r_outv <= 1'b0;
      // The sticky flag is cleared, but a simultaneous bad load re-flags it.
      r_err  <= dly_ld & w_dly_over;
      if (dly_ld) begin
        r_d <= w_dly_clamp;
      end
    end else if (dly_ld) begin
      r_fill <= '0;
      r_outv <= 1'b0;
      r_d    <= w_dly_clamp;
      r_err  <= r_err | w_dly_over;
    end else if (en) begin
      r_wp   <= w_wp_next;
      r_fill <= w_fill_next;
      r_outv <= (w_fill_next >= r_d);
    end
  end

  assign w_q = (r_d == DW'(1)) ? r_byp_q : r_ram_q;

  // Every lane uses the same select and valid terms; only the data differs.
  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      assign outp[gi*BITWIDTH +: BITWIDTH] =
        w_d_zero ? inp[gi*BITWIDTH +: BITWIDTH] :
        (r_outv  ? w_q[gi*BITWIDTH +: BITWIDTH] : '0);
    end
  endgenerate

  assign outv    = w_d_zero | r_outv;
  assign dly_cur = r_d;
  assign dly_err = r_err;

endmodule
